// File: rtl/march_cm_ctrl.sv
// March C- MBIST controller: sequences six March elements on a single-port memory with
// one-cycle read latency and reports pass/fail. Optional macro: MBIST_STOP_ON_FAIL_EN.
module march_cm_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  state_t state;
  state_t state_next;

  // Operation cursor: element index, address, and read/write phase within two-op elements.
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  phase;
  logic [2:0]            elem_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  phase_next;

  logic two_op;
  logic descending;
  logic at_end;
  logic last_op;
  logic is_write;
  logic op_en;
  logic stop_hit;
  logic mismatch;
  logic accept;

  logic                  cmp_valid;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [2:0]            cmp_elem;
  logic                  pass_q;

  assign accept = (state == IDLE) && start;

  always_comb begin
    two_op     = (elem >= 3'd1) && (elem <= 3'd4);
    descending = (elem == 3'd3) || (elem == 3'd4);
    at_end     = descending ? (addr == '0) : (addr == LAST_ADDR);
    last_op    = (elem == 3'd5) && (addr == LAST_ADDR);
    if (elem == 3'd0)      is_write = 1'b1;
    else if (elem == 3'd5) is_write = 1'b0;
    else                   is_write = phase;
  end

  // Cursor advance for the next cycle; descending elements E3/E4 start at the top address.
  always_comb begin
    elem_next  = elem;
    addr_next  = addr;
    phase_next = phase;
    if (two_op && !phase) begin
      phase_next = 1'b1;
    end else begin
      phase_next = 1'b0;
      if (at_end) begin
        if (elem != 3'd5) begin
          elem_next = elem + 3'd1;
          addr_next = ((elem_next == 3'd3) || (elem_next == 3'd4)) ? LAST_ADDR : '0;
        end
      end else begin
        addr_next = descending ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
      end
    end
  end

  assign mismatch = cmp_valid && (rdata != cmp_exp);

`ifdef MBIST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch && (state == RUN);
`else
  assign stop_hit = 1'b0;
`endif

  assign op_en = (state == RUN) && !stop_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        if (stop_hit)     state_next = DONE;
        else if (last_op) state_next = DRAIN;
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
    write_read = op_en && is_write;
    address    = addr;
    wdata      = {DATA_WIDTH{(elem == 3'd1) || (elem == 3'd3)}};
    pass       = (state == DONE) ? (fail_count == '0) : pass_q;
  end

  // The cursor freezes on the last E5 read so address holds through DRAIN and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (accept) begin
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (op_en && !last_op) begin
      elem  <= elem_next;
      addr  <= addr_next;
      phase <= phase_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= '0;
    end else begin
      cmp_valid <= op_en && !is_write;
      cmp_exp   <= {DATA_WIDTH{(elem == 3'd2) || (elem == 3'd4)}};
      cmp_addr  <= addr;
      cmp_elem  <= elem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else if (accept) begin
      fail_count <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
    end else if (mismatch) begin
      if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_ONE;
      if (fail_count == '0) begin
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pass_q <= 1'b0;
    else if (state == DONE)  pass_q <= (fail_count == '0);
    else if (accept)         pass_q <= 1'b0;
  end

endmodule

// File: tb/tb_march_cm_ctrl.sv
// Directed bench for march_cm_ctrl: behavioural memory with an optional stuck-at-0 fault
// on address 5 bit 6, run logging, and per-scenario checks.
module tb_march_cm_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_count;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem;
  logic       write_read;
  logic [3:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int checks;
  int failures;

  logic [7:0] mem [0:15];
  logic       fault_en;

  logic       wr_log   [0:399];
  logic [3:0] addr_log [0:399];
  logic [7:0] wd_log   [0:399];
  logic       busy_log [0:399];
  logic       done_log [0:399];

  march_cm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model with optional stuck-at-0 cell
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rdata = 8'h00;
  end

  always @(posedge clk) begin
    if (write_read) begin
      if (fault_en && address == 4'd5) mem[address] <= wdata & 8'hBF;
      else                             mem[address] <= wdata;
    end
    rdata <= mem[address];
  end

  // driver: start pulse at cycle 0, optional second start, log until done+2
  task automatic run_seq(input int extra_start, input int max_cyc, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      wr_log[i] = 1'b0; addr_log[i] = '0; wd_log[i] = '0; busy_log[i] = 1'b0; done_log[i] = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= max_cyc; n++) begin
      wr_log[n]   = write_read;
      addr_log[n] = address;
      wd_log[n]   = wdata;
      busy_log[n] = busy;
      done_log[n] = done;
      if (done && done_cyc < 0) done_cyc = n;
      start = (n == extra_start);
      if (done_cyc >= 0 && n >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    fault_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, write_read} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got busy/done/pass/wr=%b expected 0000", {busy, done, pass, write_read});
    end
    checks++;
    if ({fail_count, fail_addr, fail_elem} !== 15'd0) begin
      failures++;
      $display("FAIL reset_fail_regs: got %h/%h/%h expected 0/0/0", fail_count, fail_addr, fail_elem);
    end
    checks++;
    if ({address, wdata} !== 12'd0) begin
      failures++;
      $display("FAIL reset_addr_data: got addr=%h wdata=%h expected 0/0", address, wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fault_free;
    int dc;
    int bad;
    run_seq(-1, 300, dc);
    checks++;
    if (dc !== 162) begin
      failures++;
      $display("FAIL clean_done_cycle: got %0d expected 162", dc);
    end
    bad = 0;
    for (int n = 1; n <= 163; n++) if (busy_log[n] !== (n <= 161)) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clean_busy_window: %0d cycles wrong, expected busy on cycles 1..161", bad);
    end
    checks++;
    if (done_log[163] !== 1'b0) begin
      failures++;
      $display("FAIL clean_done_pulse: done at 163=%b expected 0", done_log[163]);
    end
    checks++;
    if (pass !== 1'b1 || fail_count !== 8'd0) begin
      failures++;
      $display("FAIL clean_result: pass=%b count=%0d expected 1/0", pass, fail_count);
    end
    checks++;
    if (wr_log[1] !== 1'b1 || addr_log[1] !== 4'd0 || wd_log[1] !== 8'h00) begin
      failures++;
      $display("FAIL first_op: wr=%b addr=%h wdata=%h expected 1/0/00", wr_log[1], addr_log[1], wd_log[1]);
    end
    checks++;
    if (wr_log[160] !== 1'b0 || addr_log[160] !== 4'd15 || wr_log[161] !== 1'b0 || addr_log[161] !== 4'd15) begin
      failures++;
      $display("FAIL last_read_drain: wr=%b%b addr=%h/%h expected 00 f/f",
               wr_log[160], wr_log[161], addr_log[160], addr_log[161]);
    end
  endtask

  // E3 occupies cycles 81..112: r0/w1 pairs from address 15 down to 0
  task automatic test_e3_order;
    int dc;
    logic [3:0] ea;
    logic       ew;
    run_seq(-1, 300, dc);
    for (int k = 0; k < 32; k++) begin
      ea = 4'(15 - k / 2);
      ew = (k % 2 == 1);
      checks++;
      if (addr_log[81 + k] !== ea || wr_log[81 + k] !== ew || (ew && wd_log[81 + k] !== 8'hFF)) begin
        failures++;
        $display("FAIL e3_op[%0d]: addr=%h wr=%b wdata=%h expected addr=%h wr=%b wdata=ff",
                 k, addr_log[81 + k], wr_log[81 + k], wd_log[81 + k], ea, ew);
      end
    end
  endtask

  task automatic test_stuck_at;
    int dc;
    int late_ops;
    fault_en = 1'b1;
    run_seq(-1, 300, dc);
`ifdef MBIST_STOP_ON_FAIL_EN
    checks++;
    if (dc !== 61) begin
      failures++;
      $display("FAIL sa_done_cycle: got %0d expected 61", dc);
    end
    checks++;
    if (fail_count !== 8'd1) begin
      failures++;
      $display("FAIL sa_count: got %0d expected 1", fail_count);
    end
    late_ops = 0;
    for (int n = 60; n <= 63; n++) if (wr_log[n] !== 1'b0 || busy_log[n + 1] !== 1'b0) late_ops++;
    checks++;
    if (late_ops !== 0) begin
      failures++;
      $display("FAIL sa_no_ops_after_stop: %0d cycles with activity expected 0", late_ops);
    end
`else
    late_ops = 0;
    checks++;
    if (dc !== 162) begin
      failures++;
      $display("FAIL sa_done_cycle: got %0d expected 162", dc);
    end
    checks++;
    if (fail_count !== 8'd2) begin
      failures++;
      $display("FAIL sa_count: got %0d expected 2", fail_count);
    end
`endif
    checks++;
    if (pass !== 1'b0) begin
      failures++;
      $display("FAIL sa_pass: got %b expected 0", pass);
    end
    checks++;
    if (fail_addr !== 4'd5 || fail_elem !== 3'd2) begin
      failures++;
      $display("FAIL sa_first_fail: addr=%0d elem=%0d expected 5/2", fail_addr, fail_elem);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pass !== 1'b0 || write_read !== 1'b0) begin
      failures++;
      $display("FAIL sa_result_hold: pass=%b wr=%b expected 0/0", pass, write_read);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_restart_clears;
    int dc;
    run_seq(-1, 300, dc);
    checks++;
    if (fail_count !== 8'd0 || fail_addr !== 4'd0 || fail_elem !== 3'd0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear: count=%0d addr=%0d elem=%0d pass=%b expected 0/0/0/1",
               fail_count, fail_addr, fail_elem, pass);
    end
  endtask

  task automatic test_start_ignored;
    int dc;
    run_seq(40, 300, dc);
    checks++;
    if (dc !== 162) begin
      failures++;
      $display("FAIL busy_start_done: got %0d expected 162", dc);
    end
    checks++;
    if (pass !== 1'b1 || fail_count !== 8'd0) begin
      failures++;
      $display("FAIL busy_start_result: pass=%b count=%0d expected 1/0", pass, fail_count);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_no_rerun: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run;
    int dc;
    int done_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 70; n++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_before: busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, write_read, address, wdata, fail_count, fail_addr, fail_elem} !== 31'd0) begin
      failures++;
      $display("FAIL mid_async_clear: busy=%b done=%b wr=%b addr=%h wdata=%h count=%0d expected all 0",
               busy, done, write_read, address, wdata, fail_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL mid_no_done: %0d active cycles expected 0", done_seen);
    end
    run_seq(-1, 300, dc);
    checks++;
    if (dc !== 162 || pass !== 1'b1) begin
      failures++;
      $display("FAIL mid_rerun: done=%0d pass=%b expected 162/1", dc, pass);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    fault_en = 1'b0;
    test_reset();
    test_fault_free();
    test_e3_order();
    test_stuck_at();
    test_restart_clears();
    test_start_ignored();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/march_cm_ctrl.md
Name: march_cm_ctrl

Overview:
- March C- MBIST controller driving a single-port synchronous test memory.
- Memory interface: write_read, address, wdata, rdata; rdata is registered, one-cycle read latency.
- Sits directly upstream of the memory under test.
- Sequences the six March C- elements, compares read data, reports pass/fail plus first-failure diagnostics to the top-level BIST wrapper.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- CAPACITY, 15, highest valid address; words tested = CAPACITY+1.
- CNT_WIDTH, 8, width of the saturating fail counter.

Ports:
- clk  in  1  rising-edge clock, shared with the memory.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE.
- busy  out  1  high while the test is running, including the drain cycle.
- done  out  1  one-cycle pulse at test completion.
- pass  out  1  valid from done until the next start; 1 = no mismatches.
- fail_count  out  CNT_WIDTH  number of mismatching reads, saturating.
- fail_addr  out  ADDR_WIDTH  address of the first mismatching read.
- fail_elem  out  3  March element index (0-5) of the first mismatch.
- write_read  out  1  1 = write, 0 = read, to the memory.
- address  out  ADDR_WIDTH  memory address.
- wdata  out  DATA_WIDTH  memory write data.
- rdata  in  DATA_WIDTH  memory read data; valid the cycle after a read is issued.

Behaviour:
- Reset (async, rst_n=0): every output is 0; state is IDLE; counters are cleared. Reset mid-run aborts immediately, with no done pulse.
- Background: the all-zeros pattern is D0; the all-ones pattern is D1.
- Elements:
  - E0: ascending w0.
  - E1: ascending (r0, w1).
  - E2: ascending (r1, w0).
  - E3: descending (r0, w1).
  - E4: descending (r1, w0).
  - E5: ascending r0.
- Operation issue:
  - One memory operation is issued per cycle, with no idle cycles between operations or elements.
  - In two-op elements, the read and the write to the same address occupy consecutive cycles.
  - Ascending order runs 0..CAPACITY; descending order runs CAPACITY..0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start=1; the first operation (E0, address 0, write) is driven the cycle after start.
  - RUN -> DRAIN after the last E5 read (address CAPACITY) has been issued.
  - DRAIN: write_read=0, address held, no new operation; the final compare completes here.
  - DRAIN -> DONE; DONE asserts done=1 and busy=0 for one cycle, then -> IDLE.
  - busy=1 in RUN and DRAIN only.
- Operation count: 10*(CAPACITY+1) operations. With defaults (160 operations), done is high exactly 162 cycles after the start cycle.
- Compare pipeline:
  - On each read issue, register a compare-valid flag, the expected pattern, the address, and the element index.
  - On the next cycle, compare rdata against the expected pattern.
  - On mismatch, increment fail_count (holding at all-ones). If it is the first mismatch of the run, capture fail_addr and fail_elem.
  - wdata during reads holds the element's write pattern; the memory ignores it.
- Result: pass = (fail_count==0), updated in DONE.
- start handling: start is cleared from fail_count, fail_addr, and fail_elem on acceptance. start during RUN, DRAIN, or DONE is ignored.
- Address/data outputs in IDLE: write_read=0; address and wdata hold their last values (0 after reset).

Optional Feature:
- MBIST_STOP_ON_FAIL_EN defined: on the first mismatch, the FSM leaves RUN and goes directly to DONE (no DRAIN). No further memory operations are issued; done pulses and pass=0; fail_count=1.
- Undefined: the full algorithm always runs to completion and fail_count accumulates all mismatches.

Test Plan:
- Fault-free memory, defaults, start pulse at cycle 0 -> done at cycle 162, pass=1, fail_count=0, busy high cycles 1-161.
- Address 5 bit 6 stuck-at-0 -> first mismatch in E2 (r1), fail_addr=5, fail_elem=2; fail_count=2 (E2 and E4 reads of 1); pass=0.
- Monitor address during E3 -> sequence 15,15,14,14,...,0,0 with write_read alternating 0,1; wdata=8'hFF on the writes.
- start re-asserted at cycle 40 of a run -> ignored: done still at cycle 162, results unchanged.
- rst_n low at cycle 70 for 2 cycles -> all outputs 0 asynchronously; no done pulse; a new start after release runs the full 162-cycle sequence.
- With MBIST_STOP_ON_FAIL_EN and the stuck-at-0 fault at address 5 -> done one cycle after the E2 address-5 compare, fail_count=1, no memory operations after that compare.
